// File: rtl/jtframe_snd_pkg.sv
// rtl/jtframe_snd_pkg.sv - shared sound-path types, defaults and helpers
package jtframe_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } flt_state_t;

  localparam int DEF_DIV = 1024;
  localparam int DEF_TMO = 255;

  // Lowest set bit of mask at or above start; bit 2 of the result flags a hit.
  function automatic logic [2:0] first_from(input logic [3:0] mask, input int start);
    logic [2:0] hit;
    hit = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (k >= start && mask[k]) hit = {1'b1, 2'(k)};
    end
    return hit;
  endfunction

endpackage

// File: rtl/jtframe_sample_div.sv
// rtl/jtframe_sample_div.sv - free-running sample-period divider
module jtframe_sample_div
  import jtframe_snd_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic sample
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; the strobe is the terminal count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sample = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/jtframe_flt_sched.sv
// rtl/jtframe_flt_sched.sv - time-shares one filter engine across sound channels
module jtframe_flt_sched
  import jtframe_snd_pkg::*;
#(
  parameter int CH  = 4,
  parameter int W   = 16,
  parameter int DIV = DEF_DIV,
  parameter int TMO = DEF_TMO
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] din,
  input  logic [CH-1:0]   ch_en,
  input  logic            ovr_clr,
  output logic            sample,
  output logic [W-1:0]    flt_din,
  output logic [1:0]      flt_ch,
  output logic            flt_valid,
  input  logic            flt_ready,
  input  logic [W-1:0]    flt_dout,
  input  logic            flt_ovalid,
  output logic [CH*W-1:0] dout,
  output logic            dout_stb,
  output logic            overrun,
  output logic            timeout
);

  localparam int TW = $clog2(TMO + 1);

  flt_state_t      st;
  logic [CH*W-1:0] snap;
  logic [3:0]      en_snap;
  logic [3:0]      en_pad;
  logic [1:0]      idx;
  logic [TW-1:0]   wcnt;
  logic [2:0]      first_hit;
  logic [2:0]      next_hit;

  jtframe_sample_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .sample (sample)
  );

  // Unused channel slots read as disabled so the search never lands on them.
  assign en_pad    = 4'(ch_en);
  assign first_hit = first_from(en_pad, 0);
  assign next_hit  = first_from(en_snap, int'(idx) + 1);

  // Scheduler FSM: snapshot, issue each enabled channel in order, collect results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      idx       <= 2'd0;
      flt_valid <= 1'b0;
      flt_din   <= '0;
      flt_ch    <= 2'd0;
      dout      <= '0;
      dout_stb  <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      snap      <= '0;
      en_snap   <= 4'd0;
      wcnt      <= '0;
    end else begin
      dout_stb <= 1'b0;
      // Clear first so that a set event later in this block takes priority.
      if (ovr_clr) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      if (sample && st != ST_IDLE) overrun <= 1'b1;
      case (st)
        ST_IDLE: begin
          if (sample) begin
            snap    <= din;
            en_snap <= en_pad;
            if (first_hit[2]) begin
              st        <= ST_ISSUE;
              idx       <= first_hit[1:0];
              flt_ch    <= first_hit[1:0];
              flt_din   <= din[int'(first_hit[1:0])*W +: W];
              flt_valid <= 1'b1;
            end else begin
              st       <= ST_DONE;
              dout_stb <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (flt_ready) begin
            flt_valid <= 1'b0;
            wcnt      <= '0;
            st        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flt_ovalid || wcnt == TW'(TMO - 1)) begin
            if (flt_ovalid) dout[int'(idx)*W +: W] <= flt_dout;
            else            timeout <= 1'b1;
            if (next_hit[2]) begin
              st        <= ST_ISSUE;
              idx       <= next_hit[1:0];
              flt_ch    <= next_hit[1:0];
              flt_din   <= snap[int'(next_hit[1:0])*W +: W];
              flt_valid <= 1'b1;
            end else begin
              st       <= ST_DONE;
              dout_stb <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_DONE: begin
          st <= ST_IDLE;
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_flt_sched.sv
// tb/tb_jtframe_flt_sched.sv - self-checking bench for the filter scheduler
module tb_jtframe_flt_sched;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int DIV = 64;
  localparam int TMO = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] din;
  logic [CH-1:0]   ch_en;
  logic            ovr_clr;
  logic            sample;
  logic [W-1:0]    flt_din;
  logic [1:0]      flt_ch;
  logic            flt_valid;
  logic            flt_ready;
  logic [W-1:0]    eng_data = '0;
  logic            eng_ovalid = 1'b0;
  logic [CH*W-1:0] dout;
  logic            dout_stb;
  logic            overrun;
  logic            timeout;

  logic            eng_ready;
  logic            eng_mute;
  int              eng_lat;
  logic            eng_busy = 1'b0;
  int              eng_cnt = 0;
  int              cyc = 0;
  logic [17:0]     issued_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] mdl [CH];

  typedef struct {
    logic [63:0] d;
    logic [3:0]  e;
    int          l;
    logic [63:0] exp_dout;
    int          exp_lat;
  } vec_t;
  vec_t tbl [4];

  jtframe_flt_sched #(.CH(CH), .W(W), .DIV(DIV), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .ch_en      (ch_en),
    .ovr_clr    (ovr_clr),
    .sample     (sample),
    .flt_din    (flt_din),
    .flt_ch     (flt_ch),
    .flt_valid  (flt_valid),
    .flt_ready  (flt_ready),
    .flt_dout   (eng_data),
    .flt_ovalid (eng_ovalid),
    .dout       (dout),
    .dout_stb   (dout_stb),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  assign flt_ready = eng_ready;

  // Free cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted request as {channel, sample}.
  always @(posedge clk) begin
    if (flt_valid && flt_ready) issued_q.push_back({flt_ch, flt_din});
  end

  // Engine model: result = input + 1, ovalid L edges after the accept edge.
  always @(posedge clk) begin
    eng_ovalid <= 1'b0;
    if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_ovalid <= 1'b1;
        eng_busy   <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
    if (flt_valid && flt_ready && !eng_mute) begin
      eng_data <= flt_din + 16'd1;
      if (eng_lat == 0) eng_ovalid <= 1'b1;
      else begin
        eng_busy <= 1'b1;
        eng_cnt  <= eng_lat;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  function automatic logic [63:0] mdl_pack();
    logic [63:0] p;
    for (int k = 0; k < CH; k++) p[k*W +: W] = mdl[k];
    return p;
  endfunction

  task automatic mdl_apply(input logic [63:0] d, input logic [3:0] e, input bit mute);
    for (int k = 0; k < CH; k++)
      if (e[k] && !mute) mdl[k] = d[k*W +: W] + 16'd1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_sample"},   64'(sample),    64'd0);
    chk({nm, "_valid"},    64'(flt_valid), 64'd0);
    chk({nm, "_fdin"},     64'(flt_din),   64'd0);
    chk({nm, "_fch"},      64'(flt_ch),    64'd0);
    chk({nm, "_dout"},     dout,           64'd0);
    chk({nm, "_stb"},      64'(dout_stb),  64'd0);
    chk({nm, "_overrun"},  64'(overrun),   64'd0);
    chk({nm, "_timeout"},  64'(timeout),   64'd0);
  endtask

  // One full sample period: load inputs, wait for the strobe, check results.
  task automatic run_period(input string nm, input logic [63:0] d, input logic [3:0] e,
                            input int l, input bit mute, input bit scr, input int exp_lat);
    int n, t0, start, bad;
    bit seen;
    logic [17:0] exp_q[$];
    din = d; ch_en = e; eng_lat = l; eng_mute = mute;
    @(negedge clk);
    n = 0;
    while (!sample && n < 4*DIV) begin @(negedge clk); n++; end
    chk({nm, "_sample_seen"}, 64'(sample), 64'd1);
    t0 = cyc;
    start = issued_q.size();
    if (scr) begin
      @(posedge clk); #1;
      din = {$urandom(), $urandom()};
      ch_en = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    n = 0;
    while (!dout_stb && n < 200) begin @(negedge clk); n++; end
    seen = dout_stb;
    chk({nm, "_stb_seen"}, 64'(seen), 64'd1);
    if (exp_lat >= 0) chk({nm, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    mdl_apply(d, e, mute);
    chk({nm, "_dout_model"}, dout, mdl_pack());
    for (int k = 0; k < CH; k++) if (e[k]) exp_q.push_back({2'(k), d[k*W +: W]});
    chk({nm, "_issue_cnt"}, 64'(issued_q.size() - start), 64'(exp_q.size()));
    bad = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (start + k >= issued_q.size() || issued_q[start + k] !== exp_q[k]) bad++;
    chk({nm, "_issue_seq"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, "_stb_width"}, 64'(dout_stb), 64'd0);
  endtask

  initial begin
    int n, c0, stall_bad, ovr_bad, first, l;
    bit stb_early, seen;
    logic [63:0] d;
    logic [3:0] e;

    tbl[0] = '{64'h0004_0003_0002_0001, 4'b1111, 3, 64'h0005_0004_0003_0002, 21};
    tbl[1] = '{64'h0028_001e_0014_000a, 4'b0101, 1, 64'h0005_001f_0003_000b, 7};
    tbl[2] = '{64'h1111_2222_3333_4444, 4'b0000, 2, 64'h0005_001f_0003_000b, 1};
    tbl[3] = '{64'hffff_0007_7fff_0064, 4'b1010, 2, 64'h0000_001f_8000_000b, 9};
    for (int k = 0; k < CH; k++) mdl[k] = '0;

    rst = 1'b1; din = '0; ch_en = '0; ovr_clr = 1'b0;
    eng_ready = 1'b1; eng_mute = 1'b0; eng_lat = 1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      run_period($sformatf("tbl%0d", i), tbl[i].d, tbl[i].e, tbl[i].l, 1'b0, 1'b0, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_dout_const", i), dout, tbl[i].exp_dout);
    end

    // Random periods with inputs scrambled after the snapshot.
    for (int i = 0; i < 16; i++) begin
      d = {$urandom(), $urandom()};
      e = 4'($urandom_range(0, 15));
      l = $urandom_range(1, 4);
      run_period($sformatf("rnd%0d", i), d, e, l, 1'b0, 1'b1,
                 ($countones(e) == 0) ? 1 : 1 + $countones(e) * (l + 2));
    end
    chk("rnd_no_overrun", 64'(overrun), 64'd0);

    // Engine stalls: request must hold, missed samples flag overrun.
    d = {$urandom(), $urandom()};
    din = d; ch_en = 4'b1111; eng_ready = 1'b0; eng_lat = 1; eng_mute = 1'b0;
    @(negedge clk);
    n = 0;
    while (!sample && n < 4*DIV) begin @(negedge clk); n++; end
    chk("stall_sample_seen", 64'(sample), 64'd1);
    c0 = cyc; stall_bad = 0; ovr_bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (flt_valid !== 1'b1 || flt_ch !== 2'd0 || flt_din !== d[W-1:0]) stall_bad++;
      if (overrun !== ((cyc - c0) > DIV)) ovr_bad++;
    end
    chk("stall_req_stable", 64'(stall_bad), 64'd0);
    chk("stall_overrun_timing", 64'(ovr_bad), 64'd0);
    n = 0;
    while (!sample && n < 4*DIV) begin @(negedge clk); n++; end
    ovr_clr = 1'b1;
    @(negedge clk);
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    @(negedge clk);
    chk("ovr_clr", 64'(overrun), 64'd0);
    ovr_clr = 1'b0;
    eng_ready = 1'b1;
    n = 0;
    while (!dout_stb && n < 200) begin @(negedge clk); n++; end
    chk("stall_release_stb", 64'(dout_stb), 64'd1);
    mdl_apply(d, 4'b1111, 1'b0);
    chk("stall_release_dout", dout, mdl_pack());

    // Engine never answers: every channel times out.
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("tmo_pre", 64'(timeout), 64'd0);
    run_period("tmo", {$urandom(), $urandom()}, 4'b1111, 1, 1'b1, 1'b0, -1);
    chk("tmo_flag", 64'(timeout), 64'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("tmo_clr", 64'(timeout), 64'd0);

    // Reset while waiting on the engine.
    din = {$urandom(), $urandom()}; ch_en = 4'b1111; eng_lat = 4; eng_mute = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(flt_valid && flt_ready) && n < 4*DIV) begin @(negedge clk); n++; end
    chk("rst_issue_seen", 64'(flt_valid), 64'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < CH; k++) mdl[k] = '0;
    first = 0; stb_early = 1'b0;
    for (int k = 1; k <= DIV + 4; k++) begin
      @(negedge clk);
      if (dout_stb && first == 0) stb_early = 1'b1;
      if (sample && first == 0) first = k;
    end
    chk("rst_no_stb", 64'(stb_early), 64'd0);
    chk("rst_first_sample", 64'(first + 1), 64'(DIV));
    n = 0;
    while (!dout_stb && n < 200) begin @(negedge clk); n++; end
    seen = dout_stb;
    chk("rst_resume_stb", 64'(seen), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
